imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory of the five-stage RISC-V core. Receives a framed byte stream from a host link, assembles little-endian 32-bit instructions, and issues sequential word writes into IMEM starting at address 0. Holds the fetch stage stalled until the image is loaded and verified, then releases it. It sits between the host byte link and the IMEM write port, on the opposite side of IMEM from the instruction-fetch read path.

## Interface
Parameters:
- PC_WIDTH, 32, IMEM address width (byte address)
- INST_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
- DEPTH_WORDS, 256, IMEM capacity in words; upper bound on the frame word count
- HOLD_AT_RESET, 1, reset value of core_hold

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a new load
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte this cycle
- imem_wr_en  out  1  one-cycle IMEM write strobe
- imem_wr_addr  out  PC_WIDTH  byte address of the write, word aligned
- imem_wr_data  out  INST_WIDTH  instruction word
- core_hold  out  1  high = fetch stage must deassert pc_write and IF/ID write
- load_done  out  1  level; image loaded and checksum correct
- load_err  out  2  00 none, 01 count overflow, 10 checksum mismatch
- words_loaded  out  16  number of words written in the current or last load

## Operation
- Frame format: count_lo, count_hi (16-bit word count N), then 4·N data bytes with the least-significant byte first, then one checksum byte.
- Checksum: XOR of every preceding frame byte, header bytes included.
- A byte transfers on a cycle with rx_valid && rx_ready. rx_ready is high only in HDR_LO, HDR_HI, DATA and CSUM.
- States and transitions:
  - IDLE/DONE/ERR + start → HDR_LO. The transition clears the byte index, word counter, running XOR, load_done and load_err, and sets core_hold.
  - HDR_LO + transfer → HDR_HI.
  - HDR_HI + transfer:
    - N > DEPTH_WORDS → ERR with load_err=01. No writes are issued.
    - N == 0 → CSUM.
    - otherwise → DATA.
  - DATA: each transfer shifts the byte into lane byte_idx (0..3). On the 4th byte:
    - write the word at address words_loaded·4;
    - increment words_loaded;
    - if words_loaded reaches N, go to CSUM.
  - CSUM + transfer:
    - byte == running XOR → DONE: load_done=1, core_hold=0.
    - otherwise → ERR: load_err=10. core_hold stays 1.
- start in any state other than IDLE, DONE or ERR is ignored.
- Words written before a checksum error remain in IMEM. The error only keeps the core held.
- The address counter never wraps, because the overflow check bounds N.

## Timing
- Reset values:
  - state=IDLE, rx_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0
  - core_hold=HOLD_AT_RESET, load_done=0, load_err=00, words_loaded=0
- Outputs are registered.
- imem_wr_en pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. Address and data are valid in that same cycle.
- rx_ready reflects the current state. It may be high in consecutive cycles, giving a sustained rate of 1 byte/clk and one word per 4 clk.
- core_hold falls, and load_done rises, in the cycle after the checksum byte is accepted.
- reset_n low mid-frame returns every output to its reset value immediately. A partial image is not erased.

## Structure
- Shared package/include holds:
  - the state encoding;
  - the load_err codes;
  - a BYTES_PER_WORD = 4 constant.
- No sub-module is required.
- Optional: a word-assembly shift register, imem_word_packer (byte in, 32-bit word out, word_valid strobe).
- The IMEM write-port connection reuses the commented-out wr_addr/wr_data path of the fetch stage. core_hold gates pc_write and IF_ID_write.

## Test plan
- Frame 02 00, 13 00 00 00, 33 05 C4 00, checksum (XOR of all header and data bytes):
  - exactly two write pulses: addr 0x0 data 0x00000013, then addr 0x4 data 0x00C40533;
  - load_done=1, core_hold=0, words_loaded=2.
- Same frame with a corrupted checksum → both writes occur, load_err=10, core_hold stays 1, load_done=0.
- Header N=257 with DEPTH_WORDS=256 → ERR after the 2nd byte, load_err=01, zero write pulses, rx_ready=0 afterwards.
- N=0, checksum byte 0x00 → DONE with no writes, words_loaded=0.
- rx_valid toggled randomly, plus start pulsed mid-DATA → identical writes to the back-to-back case; the start pulse is ignored.
- reset_n asserted after 5 data bytes → all outputs at reset values asynchronously; a following start plus a full frame loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM boot loader: FSM encoding, error codes, word geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] LOAD_ERR_NONE = 2'b00;
    localparam logic [1:0] LOAD_ERR_OVF  = 2'b01;
    localparam logic [1:0] LOAD_ERR_CSUM = 2'b10;

    localparam int BYTES_PER_WORD = 4;

    // States from which a start request launches a new load.
    function automatic logic is_rest_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> sequential 32-bit IMEM word writes, holds the core until verified.
// Latency: write strobe one cycle after the 4th byte of a word; core release one cycle after the checksum byte.
// Backpressure: rx_ready is a pure state decode; 1 byte/clk sustained while in a receiving state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int PC_WIDTH      = 32,
    parameter int INST_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_wr_en,
    output logic [PC_WIDTH-1:0]   imem_wr_addr,
    output logic [INST_WIDTH-1:0] imem_wr_data,
    output logic                  core_hold,
    output logic                  load_done,
    output logic [1:0]            load_err,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);
    localparam logic [1:0]  LAST_LANE   = 2'(BYTES_PER_WORD - 1);

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [7:0]  count_lo;
    logic [15:0] word_count;
    logic [7:0]  run_xor;
    logic [23:0] word_buf;      // lanes 0..2 of the word being assembled; lane 3 comes straight from rx_data

    logic        xfer;
    logic        launch;
    logic [16:0] hdr_count;
    logic        hdr_overflow;
    logic        word_last_byte;
    logic        frame_last_word;

    assign xfer            = rx_valid && rx_ready;
    assign launch          = start && is_rest_state(state);
    assign hdr_count       = {1'b0, rx_data, count_lo};
    assign hdr_overflow    = hdr_count > DEPTH_LIMIT;
    assign word_last_byte  = (byte_idx == LAST_LANE);
    assign frame_last_word = (words_loaded + 16'd1) == word_count;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: walk the frame header, payload and checksum.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (xfer) state_nxt = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (xfer) begin
                    if (hdr_overflow)            state_nxt = ST_ERR;
                    else if (hdr_count == 17'd0) state_nxt = ST_CSUM;
                    else                         state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer && word_last_byte && frame_last_word) state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (xfer) state_nxt = (rx_data == run_xor) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: accept bytes only while a frame is being received.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_CSUM: rx_ready = 1'b1;
            default:                                rx_ready = 1'b0;
        endcase
    end

    // Datapath and registered outputs: checksum accumulation, word assembly, IMEM writes, status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx     <= 2'd0;
            count_lo     <= 8'd0;
            word_count   <= 16'd0;
            run_xor      <= 8'd0;
            word_buf     <= 24'd0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            core_hold    <= HOLD_AT_RESET;
            load_done    <= 1'b0;
            load_err     <= LOAD_ERR_NONE;
            words_loaded <= 16'd0;
        end else begin
            imem_wr_en <= 1'b0;
            if (launch) begin
                byte_idx     <= 2'd0;
                run_xor      <= 8'd0;
                words_loaded <= 16'd0;
                load_done    <= 1'b0;
                load_err     <= LOAD_ERR_NONE;
                core_hold    <= 1'b1;
            end else if (xfer) begin
                run_xor <= run_xor ^ rx_data;
                case (state)
                    ST_HDR_LO: count_lo <= rx_data;
                    ST_HDR_HI: begin
                        word_count <= hdr_count[15:0];
                        if (hdr_overflow) load_err <= LOAD_ERR_OVF;
                    end
                    ST_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // Overflow check bounds N, so this shift never wraps the address.
                                imem_wr_en   <= 1'b1;
                                imem_wr_addr <= PC_WIDTH'({words_loaded, 2'b00});
                                imem_wr_data <= INST_WIDTH'({rx_data, word_buf});
                                words_loaded <= words_loaded + 16'd1;
                            end
                        endcase
                    end
                    ST_CSUM: begin
                        if (rx_data == run_xor) begin
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            load_err <= LOAD_ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frame, bad checksum, overflow, empty frame, gappy stream, mid-frame reset.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge or 1ns after the rising edge.
// Backpressure: byte sender waits on rx_ready with a bounded cycle budget.
module tb_imem_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        core_hold;
    logic        load_done;
    logic [1:0]  load_err;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    // Captured write pulses.
    int          wr_count;
    logic [31:0] wr_addr_log [0:15];
    logic [31:0] wr_data_log [0:15];

    // Good two-word frame, checksum 02^13^33^05^C4 = E3.
    logic [7:0] frame_a [0:10];

    imem_loader #(
        .PC_WIDTH(32), .INST_WIDTH(32), .DEPTH_WORDS(256), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_wr_en) begin
            if (wr_count < 16) begin
                wr_addr_log[wr_count] = imem_wr_addr;
                wr_data_log[wr_count] = imem_wr_data;
            end
            wr_count = wr_count + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte_timeout: rx_ready=%0b required=1", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_checks++; if (rx_ready !== 1'b0)      begin n_fail++; $display("FAIL reset_rx_ready: got %0b want 0", rx_ready); end
        n_checks++; if (imem_wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en: got %0b want 0", imem_wr_en); end
        n_checks++; if (imem_wr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", imem_wr_addr); end
        n_checks++; if (imem_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", imem_wr_data); end
        n_checks++; if (core_hold !== 1'b1)     begin n_fail++; $display("FAIL reset_core_hold: got %0b want 1", core_hold); end
        n_checks++; if (load_done !== 1'b0)     begin n_fail++; $display("FAIL reset_load_done: got %0b want 0", load_done); end
        n_checks++; if (load_err !== 2'b00)     begin n_fail++; $display("FAIL reset_load_err: got %b want 00", load_err); end
        n_checks++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic_frame();
        wr_count = 0;
        pulse_start();
        n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL basic_hold_after_start: got %0b want 1", core_hold); end
        n_checks++; if (rx_ready !== 1'b1)  begin n_fail++; $display("FAIL basic_ready_hdr: got %0b want 1", rx_ready); end
        for (int i = 0; i < 11; i++) begin
            send_byte(frame_a[i]);
            // 4th byte of word 0 is frame index 5: strobe is visible right after that edge.
            if (i == 5) begin
                n_checks++; if (imem_wr_en !== 1'b1) begin n_fail++; $display("FAIL basic_wr_timing: wr_en=%0b want 1", imem_wr_en); end
            end
            if (i == 10) begin
                n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_timing: got %0b want 1", load_done); end
                n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL basic_hold_timing: got %0b want 0", core_hold); end
            end
        end
        idle_cycles(3);
        n_checks++; if (wr_count !== 2) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 2", wr_count); end
        n_checks++; if (wr_addr_log[0] !== 32'h0 || wr_data_log[0] !== 32'h0000_0013)
            begin n_fail++; $display("FAIL basic_word0: addr %h data %h want 0 00000013", wr_addr_log[0], wr_data_log[0]); end
        n_checks++; if (wr_addr_log[1] !== 32'h4 || wr_data_log[1] !== 32'h00C4_0533)
            begin n_fail++; $display("FAIL basic_word1: addr %h data %h want 4 00c40533", wr_addr_log[1], wr_data_log[1]); end
        n_checks++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL basic_words: got %0d want 2", words_loaded); end
        n_checks++; if (load_err !== 2'b00)     begin n_fail++; $display("FAIL basic_err: got %b want 00", load_err); end
        n_checks++; if (rx_ready !== 1'b0)      begin n_fail++; $display("FAIL basic_ready_done: got %0b want 0", rx_ready); end
    endtask

    task automatic test_bad_checksum();
        wr_count = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(frame_a[i]);
        send_byte(8'hE2);
        idle_cycles(3);
        n_checks++; if (wr_count !== 2) begin n_fail++; $display("FAIL badcs_wr_count: got %0d want 2", wr_count); end
        n_checks++; if (wr_data_log[1] !== 32'h00C4_0533) begin n_fail++; $display("FAIL badcs_word1: got %h want 00c40533", wr_data_log[1]); end
        n_checks++; if (load_err !== 2'b10) begin n_fail++; $display("FAIL badcs_err: got %b want 10", load_err); end
        n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL badcs_hold: got %0b want 1", core_hold); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL badcs_done: got %0b want 0", load_done); end
    endtask

    task automatic test_overflow();
        wr_count = 0;
        pulse_start();
        n_checks++; if (load_err !== 2'b00) begin n_fail++; $display("FAIL ovf_err_cleared: got %b want 00", load_err); end
        send_byte(8'h01);
        send_byte(8'h01);   // N = 257
        n_checks++; if (load_err !== 2'b01) begin n_fail++; $display("FAIL ovf_err: got %b want 01", load_err); end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        idle_cycles(4);
        rx_valid = 1'b0;
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %0b want 0", rx_ready); end
        n_checks++; if (wr_count !== 0)    begin n_fail++; $display("FAIL ovf_wr_count: got %0d want 0", wr_count); end
        n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %0b want 1", core_hold); end
    endtask

    task automatic test_zero_words();
        wr_count = 0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        idle_cycles(2);
        n_checks++; if (load_done !== 1'b1)     begin n_fail++; $display("FAIL zero_done: got %0b want 1", load_done); end
        n_checks++; if (load_err !== 2'b00)     begin n_fail++; $display("FAIL zero_err: got %b want 00", load_err); end
        n_checks++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL zero_words: got %0d want 0", words_loaded); end
        n_checks++; if (wr_count !== 0)         begin n_fail++; $display("FAIL zero_wr_count: got %0d want 0", wr_count); end
    endtask

    task automatic test_gappy_stream();
        wr_count = 0;
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            idle_cycles($urandom_range(0, 3));
            // Start pulse in the middle of the payload must be ignored.
            if (i == 4) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(frame_a[i]);
        end
        idle_cycles(3);
        n_checks++; if (wr_count !== 2) begin n_fail++; $display("FAIL gappy_wr_count: got %0d want 2", wr_count); end
        n_checks++; if (wr_addr_log[0] !== 32'h0 || wr_data_log[0] !== 32'h0000_0013)
            begin n_fail++; $display("FAIL gappy_word0: addr %h data %h want 0 00000013", wr_addr_log[0], wr_data_log[0]); end
        n_checks++; if (wr_addr_log[1] !== 32'h4 || wr_data_log[1] !== 32'h00C4_0533)
            begin n_fail++; $display("FAIL gappy_word1: addr %h data %h want 4 00c40533", wr_addr_log[1], wr_data_log[1]); end
        n_checks++; if (load_done !== 1'b1 || core_hold !== 1'b0)
            begin n_fail++; $display("FAIL gappy_status: done %0b hold %0b want 1 0", load_done, core_hold); end
    endtask

    task automatic test_reset_mid_frame();
        wr_count = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(frame_a[i]);   // header + 5 data bytes
        n_checks++; if (words_loaded !== 16'd1) begin n_fail++; $display("FAIL midrst_pre_words: got %0d want 1", words_loaded); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL midrst_words: got %0d want 0", words_loaded); end
        n_checks++; if (imem_wr_data !== 32'h0) begin n_fail++; $display("FAIL midrst_wr_data: got %h want 0", imem_wr_data); end
        n_checks++; if (rx_ready !== 1'b0)      begin n_fail++; $display("FAIL midrst_ready: got %0b want 0", rx_ready); end
        n_checks++; if (core_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 2'b00)
            begin n_fail++; $display("FAIL midrst_status: hold %0b done %0b err %b want 1 0 00", core_hold, load_done, load_err); end
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);
        wr_count = 0;
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(frame_a[i]);
        idle_cycles(3);
        n_checks++; if (wr_count !== 2 || wr_data_log[1] !== 32'h00C4_0533)
            begin n_fail++; $display("FAIL midrst_reload_writes: count %0d data1 %h want 2 00c40533", wr_count, wr_data_log[1]); end
        n_checks++; if (load_done !== 1'b1 || words_loaded !== 16'd2)
            begin n_fail++; $display("FAIL midrst_reload_status: done %0b words %0d want 1 2", load_done, words_loaded); end
    endtask

    initial begin
        frame_a[0] = 8'h02; frame_a[1] = 8'h00;
        frame_a[2] = 8'h13; frame_a[3] = 8'h00; frame_a[4] = 8'h00; frame_a[5] = 8'h00;
        frame_a[6] = 8'h33; frame_a[7] = 8'h05; frame_a[8] = 8'hC4; frame_a[9] = 8'h00;
        frame_a[10] = 8'hE3;
        wr_count = 0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset_n  = 1'b1;
        #3;
        test_reset();
        test_basic_frame();
        test_bad_checksum();
        test_overflow();
        test_zero_words();
        test_gappy_stream();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
